// File: rtl/memwb_pipe_reg_if.sv
// MEM/WB pipeline register bundle: MEM-side inputs, hazard controls and WB-side outputs.
interface memwb_pipe_reg_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CTRL_W = 4
);
  logic              stall;
  logic              flush;
  logic              valid_MEM;
  logic [CTRL_W-1:0] ctrl_MEM;
  logic [DATA_W-1:0] read_data_MEM;
  logic [DATA_W-1:0] ALU_out_MEM;
  logic [REG_W-1:0]  reg_dst_MEM;

  logic              valid_WB;
  logic [CTRL_W-1:0] ctrl_WB;
  logic [DATA_W-1:0] read_data_WB;
  logic [DATA_W-1:0] ALU_out_WB;
  logic [REG_W-1:0]  reg_dst_WB;
  logic [DATA_W-1:0] wb_data_WB;
  logic              reg_write_WB;
  logic              prev_valid;
  logic [REG_W-1:0]  prev_dst;
  logic [DATA_W-1:0] prev_data;

  modport master (
    output stall, flush, valid_MEM, ctrl_MEM, read_data_MEM, ALU_out_MEM, reg_dst_MEM,
    input  valid_WB, ctrl_WB, read_data_WB, ALU_out_WB, reg_dst_WB, wb_data_WB,
    input  reg_write_WB, prev_valid, prev_dst, prev_data
  );

  modport slave (
    input  stall, flush, valid_MEM, ctrl_MEM, read_data_MEM, ALU_out_MEM, reg_dst_MEM,
    output valid_WB, ctrl_WB, read_data_WB, ALU_out_WB, reg_dst_WB, wb_data_WB,
    output reg_write_WB, prev_valid, prev_dst, prev_data
  );
endinterface

// File: rtl/memwb_pipe_reg.sv
// MEM/WB pipeline register with stall/flush, write-back select and last-write history.
// Optional retired-instruction counter enabled by defining MEMWB_RETIRE_CNT_EN.
module memwb_pipe_reg #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned REG_W        = 5,
  parameter int unsigned CTRL_W       = 4,
  parameter int unsigned REGWRITE_BIT = 0,
  parameter int unsigned MEMTOREG_BIT = 1
`ifdef MEMWB_RETIRE_CNT_EN
  ,
  parameter int unsigned CNT_W        = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  memwb_pipe_reg_if.slave    bus
`ifdef MEMWB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]   retire_cnt
`endif
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] read_data_q;
  logic [DATA_W-1:0] alu_out_q;
  logic [REG_W-1:0]  reg_dst_q;
  logic              prev_valid_q;
  logic [REG_W-1:0]  prev_dst_q;
  logic [DATA_W-1:0] prev_data_q;
  logic [DATA_W-1:0] wb_data;
  logic              reg_write;

  always_comb begin
    wb_data   = ctrl_q[MEMTOREG_BIT] ? read_data_q : alu_out_q;
    reg_write = valid_q & ctrl_q[REGWRITE_BIT] & (reg_dst_q != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      ctrl_q       <= '0;
      read_data_q  <= '0;
      alu_out_q    <= '0;
      reg_dst_q    <= '0;
      prev_valid_q <= 1'b0;
      prev_dst_q   <= '0;
      prev_data_q  <= '0;
    end else begin
      if (bus.flush) begin
        // Bubble: data fields load but are masked by valid=0 and ctrl=0.
        valid_q     <= 1'b0;
        ctrl_q      <= '0;
        read_data_q <= bus.read_data_MEM;
        alu_out_q   <= bus.ALU_out_MEM;
        reg_dst_q   <= bus.reg_dst_MEM;
      end else if (!bus.stall) begin
        valid_q     <= bus.valid_MEM;
        ctrl_q      <= bus.ctrl_MEM;
        read_data_q <= bus.read_data_MEM;
        alu_out_q   <= bus.ALU_out_MEM;
        reg_dst_q   <= bus.reg_dst_MEM;
      end
      // Retired writes are architectural, so a flush still records them.
      if (!bus.stall && reg_write) begin
        prev_valid_q <= 1'b1;
        prev_dst_q   <= reg_dst_q;
        prev_data_q  <= wb_data;
      end
    end
  end

`ifdef MEMWB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_q <= '0;
    end else if (!bus.stall && valid_q) begin
      retire_cnt_q <= retire_cnt_q + 1'b1;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

  assign bus.valid_WB     = valid_q;
  assign bus.ctrl_WB      = ctrl_q;
  assign bus.read_data_WB = read_data_q;
  assign bus.ALU_out_WB   = alu_out_q;
  assign bus.reg_dst_WB   = reg_dst_q;
  assign bus.wb_data_WB   = wb_data;
  assign bus.reg_write_WB = reg_write;
  assign bus.prev_valid   = prev_valid_q;
  assign bus.prev_dst     = prev_dst_q;
  assign bus.prev_data    = prev_data_q;

endmodule

// File: tb/tb_memwb_pipe_reg.sv
// Self-checking bench for memwb_pipe_reg: vector table through a scoreboard queue plus
// hand-written reset and counter-wrap sequences.
module tb_memwb_pipe_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memwb_pipe_reg_if #(.DATA_W(32), .REG_W(5), .CTRL_W(4)) bus ();

`ifdef MEMWB_RETIRE_CNT_EN
  logic [3:0] retire_cnt;
  memwb_pipe_reg #(
    .DATA_W(32), .REG_W(5), .CTRL_W(4), .REGWRITE_BIT(0), .MEMTOREG_BIT(1), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .retire_cnt(retire_cnt)
  );
`else
  memwb_pipe_reg #(
    .DATA_W(32), .REG_W(5), .CTRL_W(4), .REGWRITE_BIT(0), .MEMTOREG_BIT(1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  typedef struct packed {
    logic        valid;
    logic [3:0]  ctrl;
    logic [31:0] wb;
    logic [4:0]  dst;
    logic        rw;
    logic        pv;
    logic [4:0]  pd;
    logic [31:0] pdata;
    logic [3:0]  cnt;
  } exp_t;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic        valid;
    logic [3:0]  ctrl;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  dst;
    exp_t        e;
  } vec_t;

  localparam int NumVec = 13;
  vec_t vecs [NumVec];
  exp_t exp_q [$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    else n_pass++;
  endtask

  task automatic drive(input logic s, input logic f, input logic v, input logic [3:0] c,
                       input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] d);
    bus.stall = s; bus.flush = f; bus.valid_MEM = v; bus.ctrl_MEM = c;
    bus.read_data_MEM = rd; bus.ALU_out_MEM = alu; bus.reg_dst_MEM = d;
  endtask

  task automatic compare_exp(input string tag, input exp_t e);
    check({tag, ".valid_WB"}, 64'(bus.valid_WB), 64'(e.valid));
    check({tag, ".ctrl_WB"}, 64'(bus.ctrl_WB), 64'(e.ctrl));
    check({tag, ".wb_data_WB"}, 64'(bus.wb_data_WB), 64'(e.wb));
    check({tag, ".reg_dst_WB"}, 64'(bus.reg_dst_WB), 64'(e.dst));
    check({tag, ".reg_write_WB"}, 64'(bus.reg_write_WB), 64'(e.rw));
    check({tag, ".prev_valid"}, 64'(bus.prev_valid), 64'(e.pv));
    check({tag, ".prev_dst"}, 64'(bus.prev_dst), 64'(e.pd));
    check({tag, ".prev_data"}, 64'(bus.prev_data), 64'(e.pdata));
`ifdef MEMWB_RETIRE_CNT_EN
    check({tag, ".retire_cnt"}, 64'(retire_cnt), 64'(e.cnt));
`endif
  endtask

  initial begin
    // stall flush valid ctrl rd alu dst | valid ctrl wb dst rw pv pd pdata cnt
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 4'h3, 32'hDEADBEEF, 32'h10, 5'd8,
                 '{1'b1, 4'h3, 32'hDEADBEEF, 5'd8, 1'b1, 1'b0, 5'd0, 32'h0, 4'd0}};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 4'h1, 32'h11111111, 32'h20, 5'd0,
                 '{1'b1, 4'h1, 32'h20, 5'd0, 1'b0, 1'b1, 5'd8, 32'hDEADBEEF, 4'd1}};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 4'h1, 32'h0, 32'h33, 5'd5,
                 '{1'b1, 4'h1, 32'h33, 5'd5, 1'b1, 1'b1, 5'd8, 32'hDEADBEEF, 4'd2}};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'h1, 32'h0, 32'h44, 5'd6,
                 '{1'b0, 4'h1, 32'h44, 5'd6, 1'b0, 1'b1, 5'd5, 32'h33, 4'd3}};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 4'h2, 32'h55, 32'h66, 5'd7,
                 '{1'b1, 4'h2, 32'h55, 5'd7, 1'b0, 1'b1, 5'd5, 32'h33, 4'd3}};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 4'h1, 32'h0, 32'hAA, 5'd9,
                 '{1'b1, 4'h2, 32'h55, 5'd7, 1'b0, 1'b1, 5'd5, 32'h33, 4'd3}};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 4'h3, 32'h123, 32'h456, 5'd12,
                 '{1'b1, 4'h2, 32'h55, 5'd7, 1'b0, 1'b1, 5'd5, 32'h33, 4'd3}};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 4'h0, 32'h789, 32'hABC, 5'd13,
                 '{1'b1, 4'h2, 32'h55, 5'd7, 1'b0, 1'b1, 5'd5, 32'h33, 4'd3}};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 4'h1, 32'h0, 32'hAA, 5'd9,
                 '{1'b1, 4'h1, 32'hAA, 5'd9, 1'b1, 1'b1, 5'd5, 32'h33, 4'd4}};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 4'h3, 32'hBB, 32'hCC, 5'd10,
                 '{1'b0, 4'h0, 32'hCC, 5'd10, 1'b0, 1'b1, 5'd5, 32'h33, 4'd4}};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 4'h1, 32'h0, 32'hDD, 5'd3,
                 '{1'b0, 4'h0, 32'hDD, 5'd3, 1'b0, 1'b1, 5'd5, 32'h33, 4'd4}};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 4'h1, 32'h0, 32'hEE, 5'd4,
                 '{1'b1, 4'h1, 32'hEE, 5'd4, 1'b1, 1'b1, 5'd5, 32'h33, 4'd4}};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 4'h1, 32'h0, 32'h0, 5'd2,
                 '{1'b0, 4'h0, 32'h0, 5'd2, 1'b0, 1'b1, 5'd4, 32'hEE, 4'd5}};

    // Reset with busy inputs: everything must read zero.
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h1234_5678, 5'd31);
    @(posedge clk); #1;
    compare_exp("reset", '0);
    check("reset.read_data_WB", 64'(bus.read_data_WB), 64'h0);
    check("reset.ALU_out_WB", 64'(bus.ALU_out_WB), 64'h0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NumVec; i++) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].ctrl,
            vecs[i].rd, vecs[i].alu, vecs[i].dst);
      exp_q.push_back(vecs[i].e);
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 64'd1, 64'd0);
      end else begin
        compare_exp($sformatf("vec%0d", i), exp_q.pop_front());
      end
      @(negedge clk);
    end

    // Reset arriving together with stall and flush wins.
    drive(1'b1, 1'b1, 1'b1, 4'h3, 32'h5, 32'h6, 5'd7);
    rst = 1'b1;
    @(posedge clk); #1;
    compare_exp("rst_mid_stall", '0);

    // Back-to-back valid writes; a 4-bit counter wraps after 16 retirements.
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      drive(1'b0, 1'b0, 1'b1, 4'h1, 32'h0, 32'(i), 5'd1);
      @(posedge clk); #1;
`ifdef MEMWB_RETIRE_CNT_EN
      if (i == 17) check("wrap.cnt16", 64'(retire_cnt), 64'd0);
      if (i == 18) check("wrap.cnt17", 64'(retire_cnt), 64'd1);
`endif
      @(negedge clk);
    end
    check("wrap.wb_data_WB", 64'(bus.wb_data_WB), 64'd18);
    check("wrap.prev_data", 64'(bus.prev_data), 64'd17);
    check("wrap.prev_dst", 64'(bus.prev_dst), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/memwb_pipe_reg.md
# memwb_pipe_reg

Parametrised MEM/WB pipeline register for the five-stage pipelined MIPS core, replacing the fixed-width latch between the memory and write-back stages. It adds a valid bit, stall (hold) and flush (bubble) control, a registered write-back data select, and a one-entry history of the last retired register write for a WB→ID bypass. An optional retired-instruction counter is compiled in by macro.

## Interface
Parameters:
- DATA_W, 32, datapath width of read data, ALU result and write-back data
- REG_W, 5, register-index width
- CTRL_W, 4, width of the WB control bundle
- REGWRITE_BIT, 0, index of RegWrite within ctrl
- MEMTOREG_BIT, 1, index of MemtoReg within ctrl
- CNT_W, 32, retire counter width (used only with the counter compiled in)

Ports (clock and reset first):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold all WB-side registers
- flush  in  1  load a bubble into WB
- valid_MEM  in  1  MEM-stage instruction is valid
- ctrl_MEM  in  CTRL_W  WB control bundle from MEM
- read_data_MEM  in  DATA_W  data-memory read value
- ALU_out_MEM  in  DATA_W  ALU result
- reg_dst_MEM  in  REG_W  destination register
- valid_WB  out  1  WB-stage instruction is valid
- ctrl_WB  out  CTRL_W  registered control
- read_data_WB, ALU_out_WB  out  DATA_W  registered data
- reg_dst_WB  out  REG_W  registered destination
- wb_data_WB  out  DATA_W  write-back value
- reg_write_WB  out  1  qualified register-file write enable
- prev_valid  out  1  history entry holds a retired write
- prev_dst  out  REG_W  history destination
- prev_data  out  DATA_W  history data
- retire_cnt  out  CNT_W  retired-instruction count (counter build only)

## Operation
- Priority each rising edge: rst > flush > stall > load.
- rst: valid_WB, ctrl_WB, read_data_WB, ALU_out_WB, reg_dst_WB, prev_valid, prev_dst, prev_data, retire_cnt all 0.
- flush: valid_WB=0, ctrl_WB=0; data/dst registers load from MEM (don't-care, not observed because valid=0).
- stall (no flush): every WB register, history and counter hold.
- load: all WB registers take their MEM inputs.
- wb_data_WB = ctrl_WB[MEMTOREG_BIT] ? read_data_WB : ALU_out_WB (combinational from registers).
- reg_write_WB = valid_WB & ctrl_WB[REGWRITE_BIT] & (reg_dst_WB != 0).
- History: on any edge with no rst/stall and reg_write_WB=1, prev_valid←1, prev_dst←reg_dst_WB, prev_data←wb_data_WB; otherwise history holds. Flush does not clear history (retired writes are architectural).
- ctrl_MEM with valid_MEM=0 is loaded but reg_write_WB stays 0.

## Timing
- Latency: MEM inputs appear on WB outputs one cycle after a load edge.
- wb_data_WB and reg_write_WB valid in the same cycle as the registers they derive from; no extra latency.
- History updates on the edge that retires the WB instruction, i.e. visible one cycle after reg_write_WB was high.
- stall held N cycles: outputs constant for N cycles; the register write repeats (idempotent), counted once.
- Simultaneous stall and flush: flush wins, bubble inserted.
- Reset mid-stall or mid-flush: reset wins, all outputs 0 next cycle.

## Configuration
- MEMWB_RETIRE_CNT_EN defined: retire_cnt present; increments by 1 on each edge with no rst, no stall, and valid_WB=1 (flush still counts the departing valid instruction); wraps from 2^CNT_W−1 to 0.
- Not defined: retire_cnt port and counter logic absent; all other behaviour identical.

## Test plan
- rst=1 one edge with nonzero inputs -> every output 0, including prev_* and retire_cnt.
- Load valid_MEM=1, ctrl=4'b0011, read_data=0xDEADBEEF, ALU_out=0x10, dst=8 -> next cycle wb_data_WB=0xDEADBEEF, reg_write_WB=1; following edge prev_dst=8, prev_data=0xDEADBEEF.
- Load ctrl=4'b0001, dst=0 -> reg_write_WB=0, history unchanged.
- stall=1 for 3 cycles while MEM inputs change -> WB outputs constant; counter increments once when stall drops.
- stall=1 and flush=1 together -> valid_WB=0, ctrl_WB=0 next cycle, history unchanged.
- Counter build, CNT_W=4, 17 consecutive valid loads -> retire_cnt wraps to 0 after 16 retirements, reads 1 after the 17th.
